// File: rtl/acq_pkg.sv
// Shared types and helpers for the acquisition write-enable controller and the frame counter.
// The trigger-delay state is only reachable when ACQ_TRIG_DELAY_EN is defined.
package acq_pkg;

    localparam int MAX_CHANNELS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        DELAY = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } acq_state_e;

    function automatic logic [31:0] FRAME_LEN(input int unsigned width);
        FRAME_LEN = 32'd1 << width;
    endfunction

endpackage

// File: rtl/acq_frame_counter.sv
// BRAM write-address counter with frame-wrap detection and completed-frame count.
// Also used by the averaging block, so it knows nothing about the controller FSM.
module acq_frame_counter
    import acq_pkg::*;
#(
    parameter int BRAM_WIDTH  = 13,
    parameter int FRAME_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clear_i,
    input  logic                   adv_i,
    input  logic [FRAME_WIDTH-1:0] n_frames_i,
    output logic [BRAM_WIDTH-1:0]  waddr_o,
    output logic [FRAME_WIDTH-1:0] frame_count_o,
    output logic                   wrap_o,
    output logic                   last_o
);

    localparam logic [BRAM_WIDTH-1:0] LAST_ADDR = BRAM_WIDTH'(FRAME_LEN(BRAM_WIDTH) - 32'd1);

    logic [BRAM_WIDTH-1:0]  waddr_q;
    logic [FRAME_WIDTH-1:0] fc_q;

    // last_o flags the final write of the final frame so the FSM can leave WRITE on that edge
    assign wrap_o        = adv_i & (waddr_q == LAST_ADDR);
    assign last_o        = wrap_o & ((fc_q + FRAME_WIDTH'(1)) == n_frames_i);
    assign waddr_o       = waddr_q;
    assign frame_count_o = fc_q;

    // Address/frame counters; the address rolls over to 0 on its own at the frame boundary
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            waddr_q <= {BRAM_WIDTH{1'b0}};
            fc_q    <= {FRAME_WIDTH{1'b0}};
        end else if (clear_i) begin
            waddr_q <= {BRAM_WIDTH{1'b0}};
            fc_q    <= {FRAME_WIDTH{1'b0}};
        end else if (adv_i) begin
            waddr_q <= waddr_q + BRAM_WIDTH'(1);
            if (wrap_o) begin
                fc_q <= fc_q + FRAME_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/acq_write_ctrl.sv
// Multi-channel BRAM write-enable controller: arms on start, aligns to address==0, writes N frames.
// Define ACQ_TRIG_DELAY_EN to insert a trig_delay-cycle DELAY state between alignment and WRITE.
module acq_write_ctrl
    import acq_pkg::*;
#(
    parameter int BRAM_WIDTH  = 13,
    parameter int N_CHANNELS  = 2,
    parameter int FRAME_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start_acq,
    input  logic                   stop_acq,
    input  logic [BRAM_WIDTH-1:0]  address,
    input  logic                   continuous,
    input  logic [FRAME_WIDTH-1:0] n_frames,
    input  logic [N_CHANNELS-1:0]  ch_mask,
    input  logic [31:0]            trig_delay,
    output logic [N_CHANNELS-1:0]  wen,
    output logic [BRAM_WIDTH-1:0]  waddr,
    output logic                   first_frame,
    output logic                   busy,
    output logic                   done,
    output logic [FRAME_WIDTH-1:0] frame_count,
    output logic [31:0]            count_cycle
);

    acq_state_e             state_q, state_d;
    logic                   start_q;
    logic                   cont_q;
    logic [N_CHANNELS-1:0]  mask_q;
    logic [FRAME_WIDTH-1:0] nfr_q;
    logic [N_CHANNELS-1:0]  wen_q;
    logic                   busy_q, done_q, first_q;
    logic [31:0]            wrap_cnt_q, count_cycle_q;

    logic                   start_edge_s, accept_s, align_s;
    logic                   cnt_clear_s, cnt_adv_s, wrap_s, last_s;
    logic [BRAM_WIDTH-1:0]  waddr_s;
    logic [FRAME_WIDTH-1:0] fc_s;

    // A start edge while ARMED is ignored; stop always wins over a simultaneous start
    assign start_edge_s = start_acq & ~start_q;
    assign accept_s     = start_edge_s & ~stop_acq & (state_q != ARMED);
    assign align_s      = (address == {BRAM_WIDTH{1'b0}});
    assign cnt_clear_s  = accept_s | ((state_q == ARMED) & align_s & ~stop_acq);
    assign cnt_adv_s    = (state_q == WRITE) & ~stop_acq;

    acq_frame_counter #(
        .BRAM_WIDTH  (BRAM_WIDTH),
        .FRAME_WIDTH (FRAME_WIDTH)
    ) u_frame_counter (
        .clk           (clk),
        .resetn        (resetn),
        .clear_i       (cnt_clear_s),
        .adv_i         (cnt_adv_s),
        .n_frames_i    (nfr_q),
        .waddr_o       (waddr_s),
        .frame_count_o (fc_s),
        .wrap_o        (wrap_s),
        .last_o        (last_s)
    );

`ifdef ACQ_TRIG_DELAY_EN
    logic [31:0] trig_q;
    logic [31:0] dly_q;

    // Delay countdown loaded at alignment; DELAY lasts trig_delay cycles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dly_q <= 32'd0;
        end else if ((state_q == ARMED) && align_s) begin
            dly_q <= trig_q - 32'd1;
        end else if ((state_q == DELAY) && (dly_q != 32'd0)) begin
            dly_q <= dly_q - 32'd1;
        end
    end
`else
    logic unused_trig_s;
    assign unused_trig_s = ^trig_delay;
`endif

    // Start-edge history and per-acquisition configuration snapshot
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_q <= 1'b0;
            cont_q  <= 1'b0;
            mask_q  <= {N_CHANNELS{1'b0}};
            nfr_q   <= {FRAME_WIDTH{1'b0}};
`ifdef ACQ_TRIG_DELAY_EN
            trig_q  <= 32'd0;
`endif
        end else begin
            start_q <= start_acq;
            if (accept_s) begin
                cont_q <= continuous;
                mask_q <= ch_mask;
                nfr_q  <= (n_frames == {FRAME_WIDTH{1'b0}}) ? FRAME_WIDTH'(1) : n_frames;
`ifdef ACQ_TRIG_DELAY_EN
                trig_q <= trig_delay;
`endif
            end
        end
    end

    // Next-state decode: stop, then restart, then the normal sequence
    always_comb begin
        state_d = state_q;
        if (stop_acq) begin
            state_d = IDLE;
        end else if (accept_s) begin
            state_d = ARMED;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                ARMED: begin
                    if (align_s) begin
`ifdef ACQ_TRIG_DELAY_EN
                        state_d = (trig_q != 32'd0) ? DELAY : WRITE;
`else
                        state_d = WRITE;
`endif
                    end else begin
                        state_d = ARMED;
                    end
                end
                DELAY: begin
`ifdef ACQ_TRIG_DELAY_EN
                    state_d = (dly_q == 32'd0) ? WRITE : DELAY;
`else
                    state_d = IDLE;
`endif
                end
                WRITE:   state_d = last_s ? DONE : WRITE;
                DONE:    state_d = cont_q ? ARMED : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register and registered outputs, all decoded from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            wen_q   <= {N_CHANNELS{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wen_q   <= (state_d == WRITE) ? mask_q : {N_CHANNELS{1'b0}};
            busy_q  <= (state_d == ARMED) || (state_d == DELAY) || (state_d == WRITE);
            done_q  <= (state_d == DONE);
            first_q <= (state_d == WRITE) &&
                       ((state_q != WRITE) || ((fc_s == {FRAME_WIDTH{1'b0}}) && !wrap_s));
        end
    end

    // Address-wrap counter, snapshotted into count_cycle on every start edge; saturates
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrap_cnt_q    <= 32'd0;
            count_cycle_q <= 32'd0;
        end else if (start_edge_s) begin
            count_cycle_q <= wrap_cnt_q;
            wrap_cnt_q    <= align_s ? 32'd1 : 32'd0;
        end else if (align_s && (wrap_cnt_q != 32'hFFFF_FFFF)) begin
            wrap_cnt_q <= wrap_cnt_q + 32'd1;
        end
    end

    assign wen         = wen_q;
    assign waddr       = waddr_s;
    assign first_frame = first_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_count = fc_s;
    assign count_cycle = count_cycle_q;

endmodule

// File: tb/tb_acq_write_ctrl.sv
// Directed bench for acq_write_ctrl with BRAM_WIDTH=4 (16-sample frames) and two channels.
module tb_acq_write_ctrl;

    localparam int BW = 4;
    localparam int NC = 2;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start_acq = 1'b0;
    logic          stop_acq = 1'b0;
    logic [BW-1:0] address = 4'd0;
    logic          continuous = 1'b0;
    logic [FW-1:0] n_frames = 16'd1;
    logic [NC-1:0] ch_mask = 2'b11;
    logic [31:0]   trig_delay = 32'd0;
    logic [NC-1:0] wen;
    logic [BW-1:0] waddr;
    logic          first_frame, busy, done;
    logic [FW-1:0] frame_count;
    logic [31:0]   count_cycle;

    int checks = 0;
    int errors = 0;
    int cyc, n_wen, n_first, n_done, n_badval, n_badaddr, n_w0, done_cyc;
    int zq[$];
    int rq[$];
    logic          wen_prev;
    logic [BW-1:0] exp_wa;

    acq_write_ctrl #(.BRAM_WIDTH(BW), .N_CHANNELS(NC), .FRAME_WIDTH(FW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start_acq   (start_acq),
        .stop_acq    (stop_acq),
        .address     (address),
        .continuous  (continuous),
        .n_frames    (n_frames),
        .ch_mask     (ch_mask),
        .trig_delay  (trig_delay),
        .wen         (wen),
        .waddr       (waddr),
        .first_frame (first_frame),
        .busy        (busy),
        .done        (done),
        .frame_count (frame_count),
        .count_cycle (count_cycle)
    );

    always #5 clk = ~clk;

    task automatic clr_stats();
        cyc = 0; n_wen = 0; n_first = 0; n_done = 0; n_badval = 0;
        n_badaddr = 0; n_w0 = 0; done_cyc = -1;
        zq.delete(); rq.delete();
        wen_prev = 1'b0; exp_wa = 4'd0;
    endtask

    // One clock: sample 1ns after the edge, then advance the free-running address
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (wen !== 2'b00) begin
            n_wen++;
            if (!wen_prev) begin
                rq.push_back(cyc);
                exp_wa = 4'd0;
            end
            if (waddr !== exp_wa) n_badaddr++;
            exp_wa = exp_wa + 4'd1;
            if (wen !== ch_mask) n_badval++;
            if (wen[0] === 1'b1) n_w0++;
        end
        wen_prev = (wen !== 2'b00);
        if (first_frame === 1'b1) n_first++;
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        address = address + 4'd1;
        if (address == 4'd0) zq.push_back(cyc);
    endtask

    task automatic do_start();
        start_acq = 1'b1;
        tick();
        start_acq = 1'b0;
    endtask

    function automatic int lat0();
        lat0 = (rq.size() > 0 && zq.size() > 0) ? rq[0] - zq[0] : -1;
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({wen, waddr, first_frame, busy, done} !== 9'd0) begin
            errors++; $display("FAIL reset_ctrl: got %h expected 0", {wen, waddr, first_frame, busy, done});
        end
        checks++;
        if ({frame_count, count_cycle} !== 48'd0) begin
            errors++; $display("FAIL reset_counts: got %h expected 0", {frame_count, count_cycle});
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        n_frames = 16'd1; ch_mask = 2'b11; continuous = 1'b0; address = 4'd5;
        clr_stats();
        do_start();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_armed: got %b expected 1", busy); end
        repeat (40) tick();
        checks++;
        if (n_wen !== 16) begin errors++; $display("FAIL single_wen_cycles: got %0d expected 16", n_wen); end
        checks++;
        if (lat0() !== 1) begin errors++; $display("FAIL single_latency: got %0d expected 1", lat0()); end
        checks++;
        if (n_done !== 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", n_done); end
        checks++;
        if (done_cyc !== 28) begin errors++; $display("FAIL single_done_cycle: got %0d expected 28", done_cyc); end
        checks++;
        if (n_badaddr !== 0 || n_badval !== 0) begin
            errors++; $display("FAIL single_waddr_wen: got %0d/%0d bad expected 0/0", n_badaddr, n_badval);
        end
        checks++;
        if ({busy, frame_count} !== {1'b0, 16'd1}) begin
            errors++; $display("FAIL single_end_state: got busy=%b fc=%0d expected busy=0 fc=1", busy, frame_count);
        end
    endtask

    task automatic test_multi();
        n_frames = 16'd3; ch_mask = 2'b11; continuous = 1'b0; address = 4'd5;
        clr_stats();
        do_start();
        repeat (70) tick();
        checks++;
        if (n_wen !== 48 || rq.size() !== 1) begin
            errors++; $display("FAIL multi_wen_cycles: got %0d in %0d runs expected 48 in 1", n_wen, rq.size());
        end
        checks++;
        if (n_first !== 16) begin errors++; $display("FAIL multi_first_frame: got %0d expected 16", n_first); end
        checks++;
        if (frame_count !== 16'd3) begin errors++; $display("FAIL multi_frame_count: got %0d expected 3", frame_count); end
        checks++;
        if (n_done !== 1 || done_cyc !== 60 || busy !== 1'b0) begin
            errors++; $display("FAIL multi_done: got n=%0d at %0d busy=%b expected n=1 at 60 busy=0", n_done, done_cyc, busy);
        end
        checks++;
        if (n_badaddr !== 0) begin errors++; $display("FAIL multi_waddr: got %0d bad expected 0", n_badaddr); end
    endtask

    task automatic test_nframes_zero();
        n_frames = 16'd0; ch_mask = 2'b11; continuous = 1'b0; address = 4'd5;
        clr_stats();
        do_start();
        repeat (40) tick();
        checks++;
        if (n_wen !== 16 || frame_count !== 16'd1) begin
            errors++; $display("FAIL nframes_zero: got wen=%0d fc=%0d expected wen=16 fc=1", n_wen, frame_count);
        end
    endtask

    task automatic test_continuous();
        n_frames = 16'd1; ch_mask = 2'b11; continuous = 1'b1; address = 4'd5;
        clr_stats();
        do_start();
        repeat (68) tick();
        checks++;
        if (n_done !== 2) begin errors++; $display("FAIL cont_done_count: got %0d expected 2", n_done); end
        checks++;
        if (rq.size() !== 2) begin
            errors++; $display("FAIL cont_windows: got %0d expected 2", rq.size());
        end else if (rq[1] - rq[0] !== 32) begin
            checks++;
            errors++; $display("FAIL cont_rearm_gap: got %0d expected 32", rq[1] - rq[0]);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL cont_rearmed_busy: got %b expected 1", busy); end
        stop_acq = 1'b1;
        tick();
        stop_acq = 1'b0;
        continuous = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL cont_stop: got %b expected 00", {busy, done}); end
        repeat (5) tick();
    endtask

    task automatic test_stop();
        int wen_before;
        n_frames = 16'd3; ch_mask = 2'b11; continuous = 1'b0; address = 4'd5;
        clr_stats();
        do_start();
        repeat (31) tick();
        checks++;
        if (wen !== 2'b11 || first_frame !== 1'b0) begin
            errors++; $display("FAIL stop_pre_frame1: got wen=%b ff=%b expected wen=11 ff=0", wen, first_frame);
        end
        stop_acq = 1'b1;
        tick();
        stop_acq = 1'b0;
        checks++;
        if ({wen, busy, done} !== 4'b0000) begin
            errors++; $display("FAIL stop_next_cycle: got %b expected 0000", {wen, busy, done});
        end
        wen_before = n_wen;
        repeat (60) tick();
        checks++;
        if (n_done !== 0 || n_wen !== wen_before) begin
            errors++; $display("FAIL stop_aftermath: got done=%0d wen=%0d expected 0 and %0d", n_done, n_wen, wen_before);
        end
    endtask

    task automatic test_restart();
        n_frames = 16'd1; ch_mask = 2'b11; continuous = 1'b0; address = 4'd5;
        clr_stats();
        do_start();
        repeat (20) tick();
        do_start();
        checks++;
        if ({wen, busy, done} !== 4'b0010) begin
            errors++; $display("FAIL restart_armed: got %b expected 0010", {wen, busy, done});
        end
        repeat (40) tick();
        checks++;
        if (n_done !== 1 || n_wen !== 26) begin
            errors++; $display("FAIL restart_result: got done=%0d wen=%0d expected 1 and 26", n_done, n_wen);
        end
        checks++;
        if (rq.size() !== 2 || done_cyc !== 44) begin
            errors++; $display("FAIL restart_window: got runs=%0d done@%0d expected 2 and 44", rq.size(), done_cyc);
        end
    endtask

    task automatic test_mask_zero();
        n_frames = 16'd1; ch_mask = 2'b00; continuous = 1'b0; address = 4'd5;
        clr_stats();
        do_start();
        repeat (40) tick();
        checks++;
        if (n_wen !== 0 || n_done !== 1 || done_cyc !== 28) begin
            errors++; $display("FAIL mask_zero: got wen=%0d done=%0d@%0d expected 0, 1@28", n_wen, n_done, done_cyc);
        end
        checks++;
        if (n_first !== 16 || frame_count !== 16'd1) begin
            errors++; $display("FAIL mask_zero_ff: got ff=%0d fc=%0d expected 16 and 1", n_first, frame_count);
        end
    endtask

    task automatic test_delay();
        int exp_lat;
`ifdef ACQ_TRIG_DELAY_EN
        exp_lat = 8;
`else
        exp_lat = 1;
`endif
        n_frames = 16'd1; ch_mask = 2'b11; continuous = 1'b0; address = 4'd5; trig_delay = 32'd7;
        clr_stats();
        do_start();
        repeat (45) tick();
        checks++;
        if (lat0() !== exp_lat) begin errors++; $display("FAIL delay7_latency: got %0d expected %0d", lat0(), exp_lat); end
        checks++;
        if (n_wen !== 16 || n_done !== 1 || n_badaddr !== 0) begin
            errors++; $display("FAIL delay7_window: got wen=%0d done=%0d bad=%0d expected 16,1,0", n_wen, n_done, n_badaddr);
        end
        trig_delay = 32'd0; address = 4'd5;
        clr_stats();
        do_start();
        repeat (40) tick();
        checks++;
        if (lat0() !== 1 || done_cyc !== 28) begin
            errors++; $display("FAIL delay0_timing: got lat=%0d done@%0d expected 1 and 28", lat0(), done_cyc);
        end
    endtask

    task automatic test_count_mask();
        n_frames = 16'd1; ch_mask = 2'b10; continuous = 1'b0; address = 4'd5;
        clr_stats();
        do_start();
        repeat (47) tick();
        do_start();
        checks++;
        if (count_cycle !== 32'd3) begin errors++; $display("FAIL count_cycle: got %0d expected 3", count_cycle); end
        repeat (40) tick();
        checks++;
        if (n_w0 !== 0 || n_badval !== 0) begin
            errors++; $display("FAIL mask10_wen0: got w0=%0d badval=%0d expected 0 and 0", n_w0, n_badval);
        end
        checks++;
        if (n_wen !== 32 || n_done !== 2) begin
            errors++; $display("FAIL mask10_windows: got wen=%0d done=%0d expected 32 and 2", n_wen, n_done);
        end
        checks++;
        if (count_cycle !== 32'd3) begin errors++; $display("FAIL count_cycle_hold: got %0d expected 3", count_cycle); end
    endtask

    task automatic test_reset_mid();
        n_frames = 16'd1; ch_mask = 2'b11; continuous = 1'b0; address = 4'd5;
        clr_stats();
        do_start();
        repeat (15) tick();
        checks++;
        if (wen !== 2'b11) begin errors++; $display("FAIL rstmid_pre: got %b expected 11", wen); end
        resetn = 1'b0;
        #1;
        checks++;
        if ({wen, waddr, first_frame, busy, done, frame_count, count_cycle} !== 57'd0) begin
            errors++; $display("FAIL rstmid_async: got %h expected 0",
                               {wen, waddr, first_frame, busy, done, frame_count, count_cycle});
        end
        #2;
        resetn = 1'b1;
        repeat (30) tick();
        checks++;
        if (busy !== 1'b0 || n_done !== 0) begin
            errors++; $display("FAIL rstmid_after: got busy=%b done=%0d expected 0 and 0", busy, n_done);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_nframes_zero();
        test_continuous();
        test_stop();
        test_restart();
        test_mask_zero();
        test_delay();
        test_count_mask();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
